// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: issues in-order fetches at current_pc, tracks
// outstanding requests, buffers returned instructions with their PC, and
// flushes/discards on redirect.
module ifu_fetch_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] FULL_LEVEL = (CW+1)'(DEPTH);

  logic [CW-1:0]   count_reg, count_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   drop_reg, drop_next;
  logic [PW-1:0]   q_head_reg, q_head_next, q_tail_reg, q_tail_next;
  logic [PW-1:0]   pf_head_reg, pf_head_next, pf_tail_reg, pf_tail_next;
  logic [ILEN-1:0] q_data_reg [DEPTH];
  logic [XLEN-1:0] q_pc_reg   [DEPTH];
  logic [XLEN-1:0] pf_pc_reg  [DEPTH];

  logic [CW:0] occupancy;
  logic        fire;
  logic        pop;
  logic        discard;
  logic        enq;
  logic        deq;

  // Handshake decode and PC-register control; space is reserved for every
  // outstanding request so a response can never find the queue full.
  always_comb begin
    occupancy      = {1'b0, count_reg} + {1'b0, inflight_reg};
    imem_req_valid = rst && !redirect_valid && (occupancy < FULL_LEVEL);
    imem_req_addr  = current_pc;
    fire           = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    pop            = imem_resp_valid && (inflight_reg != '0);
    discard        = pop && (drop_reg != '0);
    // A response arriving in the redirect cycle belongs to the old stream.
    enq            = pop && !discard && !redirect_valid;
    inst_valid     = (count_reg != '0);
    deq            = inst_valid && inst_ready;
    inst_data      = q_data_reg[q_head_reg];
    inst_pc        = q_pc_reg[q_head_reg];
    next_pc        = redirect_valid ? redirect_pc : current_pc + XLEN'(4);
    pc_stall       = !rst || !(fire || redirect_valid);
  end

  // Next-state for counters and pointers; redirect empties the queue and
  // marks every still-outstanding response for discard.
  always_comb begin
    count_next    = count_reg + CW'(enq) - CW'(deq);
    q_head_next   = deq ? q_head_reg + PW'(1) : q_head_reg;
    q_tail_next   = enq ? q_tail_reg + PW'(1) : q_tail_reg;
    inflight_next = inflight_reg + CW'(fire) - CW'(pop);
    drop_next     = drop_reg - CW'(discard);
    pf_head_next  = pop ? pf_head_reg + PW'(1) : pf_head_reg;
    pf_tail_next  = fire ? pf_tail_reg + PW'(1) : pf_tail_reg;
    if (redirect_valid) begin
      count_next  = '0;
      q_head_next = q_tail_reg;
      drop_next   = inflight_reg - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg    <= '0;
      inflight_reg <= '0;
      drop_reg     <= '0;
      q_head_reg   <= '0;
      q_tail_reg   <= '0;
      pf_head_reg  <= '0;
      pf_tail_reg  <= '0;
    end else begin
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
      q_head_reg   <= q_head_next;
      q_tail_reg   <= q_tail_next;
      pf_head_reg  <= pf_head_next;
      pf_tail_reg  <= pf_tail_next;
    end
  end

  // Per-entry storage: instruction queue and the PC FIFO of in-flight requests.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Instruction queue entry written on enqueue at the tail.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q_data_reg[gi] <= '0;
          q_pc_reg[gi]   <= '0;
        end else if (enq && (q_tail_reg == PW'(gi))) begin
          q_data_reg[gi] <= imem_resp_data;
          q_pc_reg[gi]   <= pf_pc_reg[pf_head_reg];
        end
      end

      // In-flight PC entry written when a request is accepted.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pf_pc_reg[gi] <= '0;
        end else if (fire && (pf_tail_reg == PW'(gi))) begin
          pf_pc_reg[gi] <= current_pc;
        end
      end
    end
  endgenerate

  // Responses must only arrive for accepted requests.
  always @(posedge clk) begin
    if (rst && imem_resp_valid) begin
      assert (inflight_reg != '0);
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed testbench for ifu_fetch_ctrl with a PC register model and a
// one-cycle-latency memory responder.
module tb_ifu_fetch_ctrl;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] current_pc;
  logic [XLEN-1:0] next_pc;
  logic            pc_stall;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid = 1'b0;
  logic [ILEN-1:0] imem_resp_data = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;

  int checks = 0;
  int errors = 0;
  logic resp_en = 1'b0;
  logic [XLEN-1:0] mem_q[$];

  ifu_fetch_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk(clk), .rst(rst), .current_pc(current_pc), .next_pc(next_pc),
    .pc_stall(pc_stall), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return a[31:0] ^ 32'hCAFE_0000;
  endfunction

  // PC register: holds on stall, loads next_pc otherwise.
  always @(posedge clk or negedge rst) begin
    if (!rst) current_pc <= '0;
    else if (!pc_stall) current_pc <= next_pc;
  end

  // Memory: records accepted requests, answers one per cycle (in order) while resp_en.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_q.delete();
        imem_resp_valid = 1'b0;
      end else if (resp_en && mem_q.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; resp_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    redirect_valid = 1'b1; imem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b expected 0", inst_valid); end
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b expected 0", imem_req_valid); end
    checks++;
    if (pc_stall !== 1'b1) begin errors++; $display("FAIL reset_pc_stall got %b expected 1", pc_stall); end
    checks++;
    if (inst_data !== '0) begin errors++; $display("FAIL reset_inst_data got %h expected 0", inst_data); end
    checks++;
    if (inst_pc !== '0) begin errors++; $display("FAIL reset_inst_pc got %h expected 0", inst_pc); end
    do_reset();
  endtask

  task automatic test_streaming();
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; resp_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (pc_stall !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== XLEN'(4 * c)) begin
        errors++;
        $display("FAIL stream_req c=%0d got stall=%b valid=%b addr=%h expected 0 1 %h",
                 c, pc_stall, imem_req_valid, imem_req_addr, XLEN'(4 * c));
      end
      checks++;
      if (c < 2) begin
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_fill c=%0d got inst_valid=%b expected 0", c, inst_valid); end
      end else if (inst_valid !== 1'b1 || inst_pc !== XLEN'(4 * (c - 2)) ||
                   inst_data !== mem_word(XLEN'(4 * (c - 2)))) begin
        errors++;
        $display("FAIL stream_inst c=%0d got v=%b pc=%h data=%h expected 1 %h %h", c, inst_valid,
                 inst_pc, inst_data, XLEN'(4 * (c - 2)), mem_word(XLEN'(4 * (c - 2))));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int fires;
    int k;
    do_reset();
    imem_req_ready = 1'b1; resp_en = 1'b1; inst_ready = 1'b0;
    fires = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
      checks++;
      if (c < 4) begin
        if (imem_req_valid !== 1'b1 || imem_req_addr !== XLEN'(4 * c)) begin
          errors++;
          $display("FAIL bp_req c=%0d got valid=%b addr=%h expected 1 %h", c, imem_req_valid, imem_req_addr, XLEN'(4 * c));
        end
      end else if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1 || next_pc !== 64'h14 ||
                   inst_valid !== 1'b1 || inst_pc !== 64'h0) begin
        errors++;
        $display("FAIL bp_full c=%0d got valid=%b stall=%b next=%h iv=%b ipc=%h expected 0 1 14 1 0",
                 c, imem_req_valid, pc_stall, next_pc, inst_valid, inst_pc);
      end
      tick();
    end
    checks++;
    if (fires !== 4) begin errors++; $display("FAIL bp_fire_count got %0d expected 4", fires); end
    inst_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        checks++;
        if (inst_pc !== XLEN'(4 * k) || inst_data !== mem_word(XLEN'(4 * k))) begin
          errors++;
          $display("FAIL bp_order k=%0d got pc=%h data=%h expected %h %h", k, inst_pc, inst_data,
                   XLEN'(4 * k), mem_word(XLEN'(4 * k)));
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k !== 10) begin errors++; $display("FAIL bp_resume_count got %0d expected 10", k); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    imem_req_ready = 1'b0; inst_ready = 1'b1; resp_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || pc_stall !== 1'b1 || current_pc !== 64'h0 || next_pc !== 64'h4) begin
        errors++;
        $display("FAIL mstall c=%0d got valid=%b stall=%b pc=%h next=%h expected 1 1 0 4",
                 c, imem_req_valid, pc_stall, current_pc, next_pc);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (pc_stall !== 1'b0) begin errors++; $display("FAIL mstall_release got stall=%b expected 0", pc_stall); end
    tick();
    @(negedge clk);
    checks++;
    if (current_pc !== 64'h4) begin errors++; $display("FAIL mstall_advance got pc=%h expected 4", current_pc); end
    tick();
  endtask

  task automatic test_pc_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    checks++;
    if (next_pc !== 64'hFFFF_FFFF_FFFF_FFFC || pc_stall !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_redirect got next=%h stall=%b valid=%b expected fffffffffffffffc 0 0",
               next_pc, pc_stall, imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC || next_pc !== 64'h0 || pc_stall !== 1'b1) begin
      errors++;
      $display("FAIL wrap_next got addr=%h next=%h stall=%b expected fffffffffffffffc 0 1",
               imem_req_addr, next_pc, pc_stall);
    end
    imem_req_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (current_pc !== 64'h0) begin errors++; $display("FAIL wrap_pc got %h expected 0", current_pc); end
    tick();
  endtask

  task automatic test_redirect();
    int first;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 64'hC; imem_req_ready = 1'b1; resp_en = 1'b1; inst_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || next_pc !== 64'hC) begin
      errors++; $display("FAIL redir_c0 got valid=%b next=%h expected 0 c", imem_req_valid, next_pc);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hC) begin
      errors++; $display("FAIL redir_first_req got valid=%b addr=%h expected 1 c", imem_req_valid, imem_req_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (imem_req_addr !== 64'h10) begin errors++; $display("FAIL redir_req10 got %h expected 10", imem_req_addr); end
    resp_en = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'hC || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h14) begin
      errors++;
      $display("FAIL redir_setup got iv=%b ipc=%h rv=%b addr=%h expected 1 c 1 14",
               inst_valid, inst_pc, imem_req_valid, imem_req_addr);
    end
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || next_pc !== 64'h100 || pc_stall !== 1'b0) begin
      errors++;
      $display("FAIL redir_cycle got valid=%b next=%h stall=%b expected 0 100 0", imem_req_valid, next_pc, pc_stall);
    end
    tick();
    redirect_valid = 1'b0; resp_en = 1'b1; inst_ready = 1'b1;
    first = -1;
    for (int c = 0; c < 8 && first < 0; c++) begin
      @(negedge clk);
      if (inst_valid) first = c;
      if (first < 0) tick();
    end
    checks++;
    if (first !== 4 || inst_pc !== 64'h100 || inst_data !== mem_word(64'h100)) begin
      errors++;
      $display("FAIL redir_first_inst got idx=%0d pc=%h data=%h expected 4 100 %h",
               first, inst_pc, inst_data, mem_word(64'h100));
    end
    tick();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h104) begin
      errors++; $display("FAIL redir_second_inst got v=%b pc=%h expected 1 104", inst_valid, inst_pc);
    end
    tick();
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0; resp_en = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      errors++; $display("FAIL coin_req0 got valid=%b addr=%h expected 1 0", imem_req_valid, imem_req_addr);
    end
    tick();
    @(negedge clk);
    resp_en = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || imem_req_addr !== 64'h8) begin
      errors++; $display("FAIL coin_setup got iv=%b ipc=%h addr=%h expected 1 0 8", inst_valid, inst_pc, imem_req_addr);
    end
    resp_en = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h200; inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_resp_valid !== 1'b1 || inst_valid !== 1'b1 || inst_pc !== 64'h0 ||
        imem_req_valid !== 1'b0 || next_pc !== 64'h200) begin
      errors++;
      $display("FAIL coin_cycle got resp=%b iv=%b ipc=%h rv=%b next=%h expected 1 1 0 0 200",
               imem_resp_valid, inst_valid, inst_pc, imem_req_valid, next_pc);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h200) begin
      errors++;
      $display("FAIL coin_flush got iv=%b rv=%b addr=%h expected 0 1 200", inst_valid, imem_req_valid, imem_req_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL coin_drop got iv=%b pc=%h expected 0", inst_valid, inst_pc); end
    tick();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h200) begin
      errors++; $display("FAIL coin_first got iv=%b pc=%h expected 1 200", inst_valid, inst_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; resp_en = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (inst_valid !== 1'b1 || imem_req_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got iv=%b rv=%b expected 1 1", inst_valid, imem_req_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_stall !== 1'b1) begin
      errors++;
      $display("FAIL mid_async got iv=%b rv=%b stall=%b expected 0 0 1", inst_valid, imem_req_valid, pc_stall);
    end
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== XLEN'(4 * c)) begin
        errors++;
        $display("FAIL mid_restart c=%0d got valid=%b addr=%h expected 1 %h", c, imem_req_valid, imem_req_addr, XLEN'(4 * c));
      end
      checks++;
      if (inst_valid !== (c == 2) || (c == 2 && inst_pc !== 64'h0)) begin
        errors++; $display("FAIL mid_inst c=%0d got iv=%b pc=%h expected %b 0", c, inst_valid, inst_pc, c == 2);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_mem_stall();
    test_pc_wrap();
    test_redirect();
    test_redirect_coincident();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Fetch-side counterpart of the PC register: consumes current_pc and produces next_pc and stall for it.
- Issues in-order instruction-memory requests at current_pc.
- Buffers returned instructions with their PC in a small queue and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding in-flight responses.

Parameters:
- DEPTH, 4: queue entries; also the maximum outstanding plus buffered fetches (power of two, ≥2).
- XLEN, 64: PC width.
- ILEN, 32: instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- current_pc  in  XLEN  PC register output
- next_pc  out  XLEN  PC register input
- pc_stall  out  1  PC register hold
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_resp_valid  in  1  response valid; always accepted, in order
- imem_resp_data  in  ILEN  fetched instruction
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  ILEN  instruction
- inst_pc  out  XLEN  PC of inst_data
- redirect_valid  in  1  flush and refetch
- redirect_pc  in  XLEN  new fetch PC

Behaviour:
- Reset (rst low, async):
  - Queue cleared; inflight=0, drop=0.
  - Outputs: inst_valid=0, imem_req_valid=0, pc_stall=1, inst_data=0, inst_pc=0.
- State:
  - Queue count (0..DEPTH).
  - inflight (0..DEPTH): accepted requests not yet responded.
  - drop (0..inflight): responses still to be discarded.
  - PC FIFO of in-flight request addresses (DEPTH entries).
  - Invariant: count + inflight ≤ DEPTH.
- Request side:
  - imem_req_valid = rst && !redirect_valid && (count + inflight < DEPTH).
  - imem_req_addr = current_pc.
  - fire = imem_req_valid && imem_req_ready; on fire, push current_pc into the PC FIFO and increment inflight.
- PC control:
  - next_pc = redirect_valid ? redirect_pc : current_pc + 4, with 64-bit wrap (0xFFFF_FFFF_FFFF_FFFC + 4 = 0).
  - pc_stall = !(fire || redirect_valid).
- Response side:
  - On imem_resp_valid, pop the PC FIFO and decrement inflight.
  - If drop > 0: discard the response and decrement drop.
  - Otherwise: enqueue {pc, data}.
  - imem_resp_valid with inflight=0 is a protocol error; assert in simulation, ignore in RTL.
- Decode side:
  - inst_valid = count > 0; inst_data/inst_pc come from the queue head.
  - Dequeue when inst_valid && inst_ready.
  - Latency: response in cycle N into an empty queue gives inst_valid in N+1. No bypass.
- Simultaneous enqueue and dequeue when count = DEPTH is impossible (space is reserved). Enqueue and dequeue in the same cycle leaves count unchanged.
- Redirect (cycle R):
  - No request issued in R.
  - Queue flushed (count=0 in R+1); a dequeue in R is still honoured by the handshake but the entry is lost anyway.
  - drop(R+1) = inflight(R) − imem_resp_valid(R). A response in R is itself discarded.
  - PC FIFO keeps the entries for the in-flight requests so the pops stay aligned.
  - First request at redirect_pc in R+1 if there is space.
- Back-to-back redirects: each recomputes drop from the current inflight.
- Full: count + inflight = DEPTH → imem_req_valid=0, pc_stall=1.
- Reset mid-operation: all state cleared immediately. In-flight responses after reset are not tracked; the memory system resets concurrently.

Test Plan:
- Streaming: imem_req_ready=1, response 1 cycle after request, inst_ready=1, PC from 0 → inst_pc sequence 0,4,8,12,… one per cycle after fill; pc_stall=0 throughout.
- Backpressure: inst_ready=0, DEPTH=4 → exactly 4 requests (0,4,8,12), then imem_req_valid=0, pc_stall=1; resume gives in-order delivery, no loss.
- Memory stall: imem_req_ready=0 for 5 cycles → current_pc held, pc_stall=1, next_pc=current_pc+4.
- Redirect with 2 in flight (0x10, 0x14) and 1 buffered: redirect_pc=0x100 → next_pc=0x100; both late responses dropped; first inst_pc=0x100.
- Redirect coincident with a response and inst handshake → that response is dropped; drop = inflight−1; queue empty next cycle.
- Async reset asserted mid-stream → inst_valid=0, imem_req_valid=0, pc_stall=1 immediately; after release, fetch restarts at current_pc=0.
